// File: rtl/predictor_pkg.sv
// Shared branch-predictor definitions: branch kind encodings, checkpoint
// field layout and small arithmetic helpers used by the next-PC generator.
package predictor_pkg;

  typedef enum logic [2:0] {
    KIND_NOT_JUMP      = 3'd0,
    KIND_DIRECT_JUMP   = 3'd1,
    KIND_RET           = 3'd4,
    KIND_INDIRECT_JUMP = 3'd5,
    KIND_CALL          = 3'd6,
    KIND_JUMP          = 3'd7
  } kind_e;

  // Checkpoint layout, MSB first: {tos_ptr, count, top_entry}.
  localparam int CKPT_TOP_LSB = 0;

  function automatic int ckpt_cnt_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int ckpt_ptr_lsb(input int addr_w, input int cnt_w);
    return addr_w + cnt_w;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/npc_gen_if.sv
// Bundle of fetch-side prediction inputs, EX redirect inputs and the
// next-PC / return-stack outputs of npc_gen.
interface npc_gen_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int STACK_LEN  = 16
);
  localparam int PTR_W  = $clog2(STACK_LEN);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CKPT_W = PTR_W + CNT_W + ADDR_WIDTH;

  logic                  stall;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic                  taken_pdc;
  logic [2:0]            kind_pdc;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  choice_btb_ras;
  logic                  redirect_en;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CKPT_W-1:0]     redirect_ckpt;
  logic [2:0]            redirect_kind;
  logic [ADDR_WIDTH-1:0] redirect_ret_pc;
  logic [ADDR_WIDTH-1:0] npc_pdc;
  logic [CKPT_W-1:0]     ckpt_pdc;
  logic                  ras_empty;
  logic [7:0]            ras_ovf_cnt;

  modport master (
    output stall, pc_reg, taken_pdc, kind_pdc, btb_target, choice_btb_ras,
           redirect_en, redirect_pc, redirect_ckpt, redirect_kind, redirect_ret_pc,
    input  npc_pdc, ckpt_pdc, ras_empty, ras_ovf_cnt
  );

  modport slave (
    input  stall, pc_reg, taken_pdc, kind_pdc, btb_target, choice_btb_ras,
           redirect_en, redirect_pc, redirect_ckpt, redirect_kind, redirect_ret_pc,
    output npc_pdc, ckpt_pdc, ras_empty, ras_ovf_cnt
  );

endinterface

// File: rtl/ras_spec.sv
// Speculative return-address stack: circular entry array with top pointer,
// saturating occupancy count, overflow counter and checkpoint restore.
module ras_spec
  import predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int STACK_LEN  = 16,
  localparam int PTR_W = $clog2(STACK_LEN),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  restore_en,
  input  logic [PTR_W-1:0]      restore_ptr,
  input  logic [CNT_W-1:0]      restore_cnt,
  input  logic [ADDR_WIDTH-1:0] restore_top,
  input  logic                  push_en,
  input  logic                  pop_en,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [PTR_W-1:0]      tos_ptr,
  output logic [CNT_W-1:0]      count,
  output logic [ADDR_WIDTH-1:0] top_entry,
  output logic                  empty,
  output logic [7:0]            ovf_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_LEN);

  logic [ADDR_WIDTH-1:0] stack_r [STACK_LEN];
  logic [PTR_W-1:0]      tos_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [7:0]            ovf_cnt_r;

  logic [PTR_W-1:0]      base_ptr_s;
  logic [CNT_W-1:0]      base_cnt_s;
  logic [PTR_W-1:0]      push_ptr_s;
  logic [PTR_W-1:0]      next_ptr_s;
  logic [CNT_W-1:0]      next_cnt_s;
  logic [7:0]            next_ovf_s;
  logic                  do_pop_s;

  // Next pointer/count/overflow: a restore replaces the base state, then the push or pop acts on it.
  always_comb begin
    base_ptr_s = tos_ptr_r;
    base_cnt_s = count_r;
    if (restore_en) begin
      base_ptr_s = restore_ptr;
      base_cnt_s = restore_cnt;
    end else begin
      base_ptr_s = tos_ptr_r;
      base_cnt_s = count_r;
    end
    push_ptr_s = base_ptr_s + PTR_W'(1'b1);
    do_pop_s   = pop_en && (base_cnt_s != '0);
    next_ptr_s = base_ptr_s;
    next_cnt_s = base_cnt_s;
    next_ovf_s = ovf_cnt_r;
    if (push_en) begin
      next_ptr_s = push_ptr_s;
      // At full the push silently replaces the oldest entry.
      if (base_cnt_s == FULL_CNT) begin
        next_cnt_s = base_cnt_s;
        next_ovf_s = sat_inc8(ovf_cnt_r);
      end else begin
        next_cnt_s = base_cnt_s + CNT_W'(1'b1);
        next_ovf_s = ovf_cnt_r;
      end
    end else if (do_pop_s) begin
      next_ptr_s = base_ptr_s - PTR_W'(1'b1);
      next_cnt_s = base_cnt_s - CNT_W'(1'b1);
    end else begin
      next_ptr_s = base_ptr_s;
      next_cnt_s = base_cnt_s;
    end
  end

  // Pointer, count and overflow counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tos_ptr_r <= '0;
      count_r   <= '0;
      ovf_cnt_r <= 8'd0;
    end else begin
      tos_ptr_r <= next_ptr_s;
      count_r   <= next_cnt_s;
      ovf_cnt_r <= next_ovf_s;
    end
  end

  // Entry array: checkpoint repair of the restored top, then the push write (never the same slot).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STACK_LEN; i++) begin
        stack_r[i] <= '0;
      end
    end else begin
      if (restore_en) begin
        stack_r[restore_ptr] <= restore_top;
      end
      if (push_en) begin
        stack_r[push_ptr_s] <= push_data;
      end
    end
  end

  assign tos_ptr   = tos_ptr_r;
  assign count     = count_r;
  assign top_entry = stack_r[tos_ptr_r];
  assign empty     = (count_r == '0);
  assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: rtl/npc_gen.sv
// Next-fetch-PC generator: selects redirect / fall-through / BTB / RAS target
// and drives the speculative return stack with predicted and redirect updates.
module npc_gen
  import predictor_pkg::*;
#(
  parameter int ADDR_WIDTH  = 30,
  parameter int STACK_LEN   = 16,
  parameter int FETCH_WIDTH = 2
) (
  input logic     clk,
  input logic     rstn,
  npc_gen_if.slave bus
);

  localparam int PTR_W   = $clog2(STACK_LEN);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CKPT_W  = PTR_W + CNT_W + ADDR_WIDTH;
  localparam int CNT_LSB = ckpt_cnt_lsb(ADDR_WIDTH);
  localparam int PTR_LSB = ckpt_ptr_lsb(ADDR_WIDTH, CNT_W);

  localparam logic [ADDR_WIDTH-1:0] GROUP_MASK = ~ADDR_WIDTH'(FETCH_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] GROUP_STEP = ADDR_WIDTH'(FETCH_WIDTH);

  logic [ADDR_WIDTH-1:0] fft_s;
  logic [ADDR_WIDTH-1:0] npc_s;
  logic [ADDR_WIDTH-1:0] ras_top_s;
  logic [PTR_W-1:0]      tos_ptr_s;
  logic [CNT_W-1:0]      count_s;
  logic                  ras_empty_s;
  logic [7:0]            ovf_cnt_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] push_data_s;
  logic [CKPT_W-1:0]     ckpt_s;

  assign fft_s = (bus.pc_reg & GROUP_MASK) + GROUP_STEP;

  // Stack operation for this edge: a redirect replaces any predicted update.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = bus.pc_reg + ADDR_WIDTH'(1'b1);
    if (bus.redirect_en) begin
      push_s      = (bus.redirect_kind == KIND_CALL);
      pop_s       = (bus.redirect_kind == KIND_RET);
      push_data_s = bus.redirect_ret_pc;
    end else if (!bus.stall && bus.taken_pdc) begin
      push_s      = (bus.kind_pdc == KIND_CALL);
      pop_s       = (bus.kind_pdc == KIND_RET);
      push_data_s = bus.pc_reg + ADDR_WIDTH'(1'b1);
    end else begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      push_data_s = bus.pc_reg + ADDR_WIDTH'(1'b1);
    end
  end

  // Next fetch PC selection.
  always_comb begin
    npc_s = fft_s;
    if (bus.redirect_en) begin
      npc_s = bus.redirect_pc;
    end else if (!bus.taken_pdc) begin
      npc_s = fft_s;
    end else begin
      case (bus.kind_pdc)
        KIND_NOT_JUMP:      npc_s = fft_s;
        KIND_RET:           npc_s = (bus.choice_btb_ras || ras_empty_s) ? bus.btb_target : ras_top_s;
        KIND_DIRECT_JUMP,
        KIND_INDIRECT_JUMP,
        KIND_CALL,
        KIND_JUMP:          npc_s = bus.btb_target;
        default:            npc_s = fft_s;
      endcase
    end
  end

  ras_spec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_LEN  (STACK_LEN)
  ) u_ras (
    .clk         (clk),
    .rstn        (rstn),
    .restore_en  (bus.redirect_en),
    .restore_ptr (bus.redirect_ckpt[PTR_LSB +: PTR_W]),
    .restore_cnt (bus.redirect_ckpt[CNT_LSB +: CNT_W]),
    .restore_top (bus.redirect_ckpt[CKPT_TOP_LSB +: ADDR_WIDTH]),
    .push_en     (push_s),
    .pop_en      (pop_s),
    .push_data   (push_data_s),
    .tos_ptr     (tos_ptr_s),
    .count       (count_s),
    .top_entry   (ras_top_s),
    .empty       (ras_empty_s),
    .ovf_cnt     (ovf_cnt_s)
  );

  assign ckpt_s          = {tos_ptr_s, count_s, ras_top_s};
  assign bus.npc_pdc     = npc_s;
  assign bus.ckpt_pdc    = ckpt_s;
  assign bus.ras_empty   = ras_empty_s;
  assign bus.ras_ovf_cnt = ovf_cnt_s;

endmodule
